// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: turns SPI frames from the bridge into register-file accesses.
// First byte of a frame is the command (bit7 write, bit6 burst, bits5:0 start address);
// later bytes become one-cycle write strobes or read fetches whose data returns on data_out.
// Ports:
//   clk, rst          clock, async active-high reset
//   cs_n, byte_sync,  frame select and byte level/data from the bridge
//   data_in
//   data_out          read byte back to the bridge
//   reg_addr,         register-file address, write data and one-cycle strobes
//   reg_wdata,
//   reg_we, reg_re
//   reg_rdata         read data, valid the cycle after reg_re
//   busy              registered ~cs_n
//   err, err_clr      sticky out-of-range flag and its clear
module spi_cmd_sequencer #(
  parameter int NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [5:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_FETCH,
    RD_CAPT,
    RD_HOLD
  } state_t;

  state_t     state, state_d;
  logic       byte_sync_q;
  logic       sync_rise;
  logic       burst, burst_d;
  logic [5:0] addr, addr_d;
  logic [5:0] next_addr;
  logic [7:0] data_out_d;
  logic [5:0] reg_addr_d;
  logic [7:0] reg_wdata_d;
  logic       reg_we_d, reg_re_d;
  logic       err_set, err_d;

  function automatic logic in_range(input logic [5:0] a);
    return {1'b0, a} < 7'(NUM_REGS);
  endfunction

  assign sync_rise = byte_sync & ~byte_sync_q & ~cs_n;

  // 6-bit add wraps 63 -> 0 for bursts
  assign next_addr = burst ? addr + 6'd1 : addr;

  always_comb begin
    state_d     = state;
    burst_d     = burst;
    addr_d      = addr;
    data_out_d  = data_out;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    err_set     = 1'b0;
    if (cs_n) begin
      state_d    = IDLE;
      burst_d    = 1'b0;
      addr_d     = 6'd0;
      data_out_d = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (sync_rise) begin
            burst_d = data_in[6];
            addr_d  = data_in[5:0];
            if (data_in[7]) begin
              state_d = WR_DATA;
            end else begin
              // fetch is issued so reg_re is high while in RD_FETCH
              state_d    = RD_FETCH;
              reg_addr_d = data_in[5:0];
              reg_re_d   = in_range(data_in[5:0]);
              err_set    = ~in_range(data_in[5:0]);
            end
          end
        end
        WR_DATA: begin
          if (sync_rise) begin
            reg_addr_d  = addr;
            reg_wdata_d = data_in;
            reg_we_d    = in_range(addr);
            err_set     = ~in_range(addr);
            addr_d      = next_addr;
          end
        end
        RD_FETCH: state_d = RD_CAPT;
        RD_CAPT: begin
          data_out_d = in_range(addr) ? reg_rdata : 8'h00;
          state_d    = RD_HOLD;
        end
        RD_HOLD: begin
          if (sync_rise) begin
            addr_d     = next_addr;
            reg_addr_d = next_addr;
            reg_re_d   = in_range(next_addr);
            err_set    = ~in_range(next_addr);
            state_d    = RD_FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // set wins over clear
  assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_sync_q <= 1'b0;
      burst       <= 1'b0;
      addr        <= 6'd0;
      data_out    <= 8'h00;
      reg_addr    <= 6'd0;
      reg_wdata   <= 8'h00;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      byte_sync_q <= byte_sync;
      burst       <= burst_d;
      addr        <= addr_d;
      data_out    <= data_out_d;
      reg_addr    <= reg_addr_d;
      reg_wdata   <= reg_wdata_d;
      reg_we      <= reg_we_d;
      reg_re      <= reg_re_d;
      busy        <= ~cs_n;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: drives two sequencers (NUM_REGS 16 and 64) with the same
// SPI byte stream and compares them to a frame-level access model.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst, cs_n, byte_sync, err_clr;
  logic [7:0] data_in;
  logic [7:0] data_out [2];
  logic [5:0] reg_addr [2];
  logic [7:0] reg_wdata [2];
  logic       reg_we [2];
  logic       reg_re [2];
  logic       busy [2];
  logic       err [2];
  logic [7:0] reg_rdata [2];

  logic [7:0] mem [2][64];
  logic [7:0] seed [2][64];
  logic [7:0] model [2][64];
  bit         err_exp [2];
  int         nregs [2] = '{16, 64};
  logic [7:0] pay [$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(.NUM_REGS(16)) u_a (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(data_out[0]), .reg_addr(reg_addr[0]),
    .reg_wdata(reg_wdata[0]), .reg_we(reg_we[0]), .reg_re(reg_re[0]),
    .reg_rdata(reg_rdata[0]), .busy(busy[0]), .err(err[0]),
    .err_clr(err_clr)
  );

  spi_cmd_sequencer #(.NUM_REGS(64)) u_b (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(data_out[1]), .reg_addr(reg_addr[1]),
    .reg_wdata(reg_wdata[1]), .reg_we(reg_we[1]), .reg_re(reg_re[1]),
    .reg_rdata(reg_rdata[1]), .busy(busy[1]), .err(err[1]),
    .err_clr(err_clr)
  );

  // register-file stand-ins; rdata is junk unless a read was strobed
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mem[d][i] <= seed[d][i];
        reg_rdata[d] <= 8'h00;
      end else begin
        if (reg_we[d]) mem[d][reg_addr[d]] <= reg_wdata[d];
        reg_rdata[d] <= reg_re[d] ? mem[d][reg_addr[d]] : 8'($urandom);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({data_out[d], reg_addr[d], reg_wdata[d], reg_we[d], reg_re[d],
           busy[d], err[d]} !== 27'd0) begin
        miscompares++;
        $display("FAIL %s dut%0d: do=%h addr=%h wd=%h we=%b re=%b busy=%b err=%b want all 0",
                 tag, d, data_out[d], reg_addr[d], reg_wdata[d], reg_we[d],
                 reg_re[d], busy[d], err[d]);
      end
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      err_exp[d] = 1'b0;
      vectors++;
      if (err[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL err_clr dut%0d: got %b want 0", d, err[d]);
      end
    end
  endtask

  // One chip-select frame: cmd then the bytes in pay, each held for hold cycles.
  task automatic do_frame(input logic [7:0] cmd, input int hold, input bit clr);
    bit         wr, burst, acc, in_r, we_x, re_x;
    int         nb, off, len;
    logic [5:0] a;
    logic [7:0] b, do_x;
    logic [7:0] prev [2];
    wr    = cmd[7];
    burst = cmd[6];
    nb    = pay.size();
    len   = (hold + 1 > 4) ? hold + 1 : 4;
    prev[0] = 8'h00;
    prev[1] = 8'h00;
    cs_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (busy[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL busy dut%0d: got %b want 1", d, busy[d]);
      end
    end
    for (int i = 0; i <= nb; i++) begin
      if (i == 0) b = cmd;
      else b = pay[i-1];
      acc = !(wr && i == 0);
      off = wr ? i - 1 : i;
      a   = burst ? 6'(int'(cmd[5:0]) + off) : cmd[5:0];
      byte_sync = 1'b1;
      data_in   = b;
      err_clr   = clr && i == 0;
      for (int k = 1; k <= len; k++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          in_r = int'(a) < nregs[d];
          we_x = k == 1 && acc && wr && in_r;
          re_x = k == 1 && acc && !wr && in_r;
          if (k == 1) begin
            if (acc && !in_r) err_exp[d] = 1'b1;
            else if (err_clr) err_exp[d] = 1'b0;
          end
          vectors++;
          if (reg_we[d] !== we_x) begin
            miscompares++;
            $display("FAIL reg_we dut%0d cmd=%h byte%0d k=%0d: got %b want %b",
                     d, cmd, i, k, reg_we[d], we_x);
          end
          vectors++;
          if (reg_re[d] !== re_x) begin
            miscompares++;
            $display("FAIL reg_re dut%0d cmd=%h byte%0d k=%0d: got %b want %b",
                     d, cmd, i, k, reg_re[d], re_x);
          end
          if (we_x || re_x) begin
            vectors++;
            if (reg_addr[d] !== a) begin
              miscompares++;
              $display("FAIL reg_addr dut%0d cmd=%h byte%0d: got %h want %h",
                       d, cmd, i, reg_addr[d], a);
            end
          end
          if (we_x) begin
            vectors++;
            if (reg_wdata[d] !== b) begin
              miscompares++;
              $display("FAIL reg_wdata dut%0d cmd=%h byte%0d: got %h want %h",
                       d, cmd, i, reg_wdata[d], b);
            end
            model[d][a] = b;
          end
          if (k == 1) begin
            vectors++;
            if (err[d] !== err_exp[d]) begin
              miscompares++;
              $display("FAIL err dut%0d cmd=%h byte%0d: got %b want %b",
                       d, cmd, i, err[d], err_exp[d]);
            end
          end
          do_x = prev[d];
          if (!wr && k >= 3) do_x = in_r ? model[d][a] : 8'h00;
          vectors++;
          if (data_out[d] !== do_x) begin
            miscompares++;
            $display("FAIL data_out dut%0d cmd=%h byte%0d k=%0d: got %h want %h",
                     d, cmd, i, k, data_out[d], do_x);
          end
          if (k == len) prev[d] = do_x;
        end
        if (k == 1) err_clr = 1'b0;
        if (k == hold) byte_sync = 1'b0;
      end
    end
    cs_n = 1'b1;
    byte_sync = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({data_out[d], reg_we[d], reg_re[d], busy[d], err[d]} !==
          {8'h00, 3'b000, err_exp[d]}) begin
        miscompares++;
        $display("FAIL frame_end dut%0d cmd=%h: do=%h we=%b re=%b busy=%b err=%b want 0/0/0/0/%b",
                 d, cmd, data_out[d], reg_we[d], reg_re[d], busy[d], err[d], err_exp[d]);
      end
    end
    pay.delete();
  endtask

  // bytes that must produce no strobe at all
  task automatic quiet_byte(input logic [7:0] b, input string tag);
    byte_sync = 1'b1;
    data_in   = b;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) byte_sync = 1'b0;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (reg_we[d] !== 1'b0 || reg_re[d] !== 1'b0) begin
          miscompares++;
          $display("FAIL %s dut%0d k=%0d: we=%b re=%b want 0/0",
                   tag, d, k, reg_we[d], reg_re[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs_n = 1'b1;
    byte_sync = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    for (int d = 0; d < 2; d++) begin
      err_exp[d] = 1'b0;
      for (int i = 0; i < 64; i++) begin
        seed[d][i]  = 8'($urandom);
        model[d][i] = seed[d][i];
      end
    end
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    clear_err();
    pay = '{8'h3C};
    do_frame(8'h85, 1, 1'b0);
  endtask

  task automatic test_burst_write_wrap();
    pay = '{8'h11, 8'h22, 8'h33};
    do_frame(8'hFE, 2, 1'b0);
  endtask

  task automatic test_burst_read();
    clear_err();
    pay = '{8'hA5, 8'h5A};
    do_frame(8'hC2, 1, 1'b0);
    pay = '{8'h00};
    do_frame(8'h42, 1, 1'b0);
  endtask

  task automatic test_held_sync();
    for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
    do_frame(8'hC4, 4, 1'b0);
    pay = '{8'h00, 8'h00};
    do_frame(8'h44, 4, 1'b0);
  endtask

  task automatic test_out_of_range();
    clear_err();
    pay = '{8'($urandom)};
    do_frame(8'h94, 1, 1'b0);
    pay = '{8'h00};
    do_frame(8'h14, 1, 1'b0);
    clear_err();
    do_frame(8'h14, 1, 1'b1);
  endtask

  task automatic test_abort();
    pay = '{8'($urandom)};
    do_frame(8'hC8, 1, 1'b0);
    quiet_byte(8'($urandom), "idle_byte");
    quiet_byte(8'h9C, "idle_byte");
    cs_n = 1'b0;
    @(negedge clk);
    byte_sync = 1'b1;
    data_in = 8'h8A;
    repeat (3) begin
      @(negedge clk);
      byte_sync = 1'b0;
    end
    cs_n = 1'b1;
    quiet_byte(8'hEE, "cs_rise_byte");
    do_frame(8'h0A, 1, 1'b0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) seed[d][i] = model[d][i];
    cs_n = 1'b0;
    @(negedge clk);
    byte_sync = 1'b1;
    data_in = 8'h43;
    @(negedge clk);
    byte_sync = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_frame_reset");
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pay = '{8'($urandom)};
    do_frame(8'h83, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int nb;
    for (int n = 0; n < 16; n++) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 1) == 1) cmd[5:4] = 2'b00;
      nb = $urandom_range(0, 4);
      for (int i = 0; i < nb; i++) pay.push_back(8'($urandom));
      do_frame(cmd, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_write_wrap();
    test_burst_read();
    test_held_sync();
    test_out_of_range();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
